// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 Hz timing constants for the VGA raster generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N enabled up-counter with a combinational terminal-count strobe.
module wrap_counter
  import vga_pkg::*;
#(
  parameter int N = 800
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   en,
  output coord_t count,
  output logic   wrap
);

  assign wrap = en && (int'(count) == N - 1);

  // NOTE: sequential state uses non-blocking assignment so every register
  // in the design samples pre-edge values and updates together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a 2x pixel clock; outputs are registered from next-state counters.
// Optional macro VGA_PREFETCH_EN adds NextX/NextY (coordinate of the following pixel).
module vga_timing_gen
  import vga_pkg::coord_t;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_PREFETCH_EN
  ,
  output logic [9:0] NextX,
  output logic [9:0] NextY
`endif
);

  localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  coord_t hc, vc, h_nxt, v_nxt;
  logic   h_wrap, v_wrap;
  logic   running;
  logic   ls_nxt;

  wrap_counter #(.N(H_TOT)) u_hcnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (pix_ce),
    .count (hc),
    .wrap  (h_wrap)
  );

  wrap_counter #(.N(V_TOT)) u_vcnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (h_wrap),
    .count (vc),
    .wrap  (v_wrap)
  );

  assign DrawX      = hc;
  assign DrawY      = vc;
  assign VGA_SYNC_N = 1'b0;

  // Mirror of what the counters will hold after this edge, so the decoded
  // strobes register in lockstep with DrawX/DrawY.
  // NOTE: every always_comb output gets a default first; no path leaves a
  // signal unassigned, so no latch is inferred.
  always_comb begin
    h_nxt = hc;
    v_nxt = vc;
    if (pix_ce) h_nxt = h_wrap ? '0 : hc + coord_t'(1);
    if (h_wrap) v_nxt = v_wrap ? '0 : vc + coord_t'(1);
    // First edge out of reset starts line 0 of frame 0.
    ls_nxt = !running || h_wrap;
  end

`ifdef VGA_PREFETCH_EN
  coord_t nx_nxt, ny_nxt;

  always_comb begin
    nx_nxt = h_nxt + coord_t'(1);
    ny_nxt = v_nxt;
    if (int'(h_nxt) == H_TOT - 1) begin
      nx_nxt = '0;
      ny_nxt = (int'(v_nxt) == V_TOT - 1) ? '0 : v_nxt + coord_t'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      NextX <= 10'd1;
      NextY <= 10'd0;
    end else begin
      NextX <= nx_nxt;
      NextY <= ny_nxt;
    end
  end
`endif

  // NOTE: reset is synchronous; nothing here is sampled outside the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      running     <= 1'b0;
      pix_ce      <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      // Held low on the first edge so pixel (0,0) gets its full two cycles.
      pix_ce      <= running && !pix_ce;
      VGA_HS      <= !(int'(h_nxt) >= HS_START && int'(h_nxt) < HS_END);
      VGA_VS      <= !(int'(v_nxt) >= VS_START && int'(v_nxt) < VS_END);
      VGA_BLANK_N <= (int'(h_nxt) < H_VISIBLE) && (int'(v_nxt) < V_VISIBLE);
      line_start  <= ls_nxt;
      frame_start <= ls_nxt && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: raster-arithmetic reference model, a full-size and a
// small-timing instance, directed timing pins and randomized reset stimulus.
module tb_vga_timing_gen;

  // Small raster so full frames fit in a short run: 15 x 13, frame = 390 Clk.
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 3;

  logic Clk = 1'b0;
  logic Reset;
  logic chk_on = 1'b0;
  longint m = 0;   // edges since the last edge that sampled Reset=1

  int n_tests = 0;
  int n_fail  = 0;

  logic       d_ce, d_hs, d_vs, d_bl, d_sn, d_ls, d_fs;
  logic [9:0] d_x, d_y, d_nx, d_ny;
  logic       s_ce, s_hs, s_vs, s_bl, s_sn, s_ls, s_fs;
  logic [9:0] s_x, s_y, s_nx, s_ny;

  always #10 Clk = ~Clk;

  vga_timing_gen u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_ce      (d_ce),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .VGA_HS      (d_hs),
    .VGA_VS      (d_vs),
    .VGA_BLANK_N (d_bl),
    .VGA_SYNC_N  (d_sn),
    .line_start  (d_ls),
    .frame_start (d_fs)
`ifdef VGA_PREFETCH_EN
    ,
    .NextX       (d_nx),
    .NextY       (d_ny)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_ce      (s_ce),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .VGA_HS      (s_hs),
    .VGA_VS      (s_vs),
    .VGA_BLANK_N (s_bl),
    .VGA_SYNC_N  (s_sn),
    .line_start  (s_ls),
    .frame_start (s_fs)
`ifdef VGA_PREFETCH_EN
    ,
    .NextX       (s_nx),
    .NextY       (s_ny)
`endif
  );

`ifndef VGA_PREFETCH_EN
  assign d_nx = '0;
  assign d_ny = '0;
  assign s_nx = '0;
  assign s_ny = '0;
`endif

  always @(posedge Clk) m <= Reset ? 64'sd0 : m + 1;

  function automatic logic [47:0] pack(input logic ce, input logic [9:0] x, y,
                                       input logic hs, vs, bl, sn, ls, fs,
                                       input logic [9:0] nx, ny);
    return {ce, x, y, hs, vs, bl, sn, ls, fs, nx, ny, 1'b0};
  endfunction

  // Expected outputs from the raster rules: cycle k after reset is pixel k/2,
  // phase k%2; pixel p sits at (p mod Htot, (p div Htot) mod Vtot).
  function automatic logic [47:0] model(input int hv, hf, hsy, hb, vv, vf, vsy, vb,
                                        input longint mm);
    int htot, vtot, x, y, nx, ny;
    longint k, p;
    logic ce, ls;
    logic [9:0] enx, eny;
    htot = hv + hf + hsy + hb;
    vtot = vv + vf + vsy + vb;
`ifdef VGA_PREFETCH_EN
    enx = 10'd1;
    eny = 10'd0;
`else
    enx = 10'd0;
    eny = 10'd0;
`endif
    if (mm == 0)
      return pack(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, enx, eny);
    k  = mm - 1;
    p  = k / 2;
    ce = (k % 2) == 1;
    x  = int'(p % htot);
    y  = int'((p / htot) % vtot);
    nx = int'((p + 1) % htot);
    ny = int'(((p + 1) / htot) % vtot);
    ls = !ce && (x == 0);
`ifdef VGA_PREFETCH_EN
    enx = 10'(nx);
    eny = 10'(ny);
`endif
    return pack(ce, 10'(x), 10'(y),
                !(x >= hv + hf && x < hv + hf + hsy),
                !(y >= vv + vf && y < vv + vf + vsy),
                (x < hv) && (y < vv), 1'b0, ls, ls && (y == 0), enx, eny);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s m=%0d: got %h expected %h", name, m, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      cmp("model_full",
          pack(d_ce, d_x, d_y, d_hs, d_vs, d_bl, d_sn, d_ls, d_fs, d_nx, d_ny),
          model(640, 16, 96, 48, 480, 10, 2, 33, m));
      cmp("model_small",
          pack(s_ce, s_x, s_y, s_hs, s_vs, s_bl, s_sn, s_ls, s_fs, s_nx, s_ny),
          model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, m));
    end
  end

  initial begin
    int g, n, lines, vsl;
    Reset = 1'b1;
    @(posedge Clk);
    chk_on = 1'b1;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("rst_drawx", d_x, 0);
    check("rst_hs", d_hs, 1);
    check("rst_vs", d_vs, 1);
    check("rst_blank", d_bl, 0);
    check("rst_line_start", d_ls, 0);
    check("rst_pix_ce", d_ce, 0);

    @(posedge Clk); #1 Reset = 1'b0;
    @(posedge Clk); @(negedge Clk);
    check("first_frame_start", d_fs, 1);
    check("first_line_start", d_ls, 1);
    check("first_drawx", d_x, 0);
    check("first_pix_ce", d_ce, 0);
    check("first_blank", d_bl, 1);
    repeat (2) @(negedge Clk);
    check("drawx_after_2", d_x, 1);
    repeat (2) @(negedge Clk);
    check("drawx_after_4", d_x, 2);

    g = 0;
    while (d_hs && g < 4000) begin @(negedge Clk); g++; end
    check("hs_fall_x", d_x, 656);
    n = 0;
    while (!d_hs && n < 4000) begin @(negedge Clk); n++; end
    check("hs_low_clk", n, 192);
    check("hs_rise_x", d_x, 752);

    g = 0;
    while (!d_ls && g < 4000) begin @(negedge Clk); g++; end
    n = 0;
    do begin @(negedge Clk); n++; end while (!d_ls && n < 4000);
    check("line_period", n, 1600);

    g = 0;
    while (d_x != 10'd639 && g < 4000) begin @(negedge Clk); g++; end
    check("blank_x639", d_bl, 1);
    g = 0;
    while (d_x != 10'd640 && g < 4000) begin @(negedge Clk); g++; end
    check("blank_x640", d_bl, 0);

    g = 0;
    while (!s_fs && g < 1000) begin @(negedge Clk); g++; end
    check("small_fs_seen", s_fs, 1);
    n = 0; lines = 0; vsl = 0;
    do begin
      if (s_ls) lines++;
      if (!s_vs) vsl++;
      @(negedge Clk);
      n++;
    end while (!s_fs && n < 2000);
    check("small_frame_period", n, 390);
    check("small_lines_per_frame", lines, 13);
    check("small_vs_low_clk", vsl, 60);

`ifdef VGA_PREFETCH_EN
    g = 0;
    while (!(s_x == 10'd14 && s_y == 10'd12) && g < 1000) begin @(negedge Clk); g++; end
    check("small_pf_last_x", s_nx, 0);
    check("small_pf_last_y", s_ny, 0);
    g = 0;
    while (!(d_x == 10'd5 && d_y == 10'd5) && g < 20000) begin @(negedge Clk); g++; end
    check("pf_5_5_x", d_nx, 6);
    check("pf_5_5_y", d_ny, 5);
    g = 0;
    while (!(d_x == 10'd799 && d_y == 10'd10) && g < 20000) begin @(negedge Clk); g++; end
    check("pf_799_10_x", d_nx, 0);
    check("pf_799_10_y", d_ny, 11);
`endif

    // One-cycle reset in the middle of a line.
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check("midrst_drawx", d_x, 0);
    check("midrst_drawy", d_y, 0);
    check("midrst_hs", d_hs, 1);
    check("midrst_vs", d_vs, 1);
    check("midrst_blank", d_bl, 0);
    @(posedge Clk); @(negedge Clk);
    check("midrst_frame_start", d_fs, 1);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(300, 4000)) @(posedge Clk);
      #1 Reset = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge Clk);
      #1 Reset = 1'b0;
    end
    repeat (3000) @(posedge Clk);
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
